// File: rtl/motoro3_nphase_line_gen_if.sv
// Control inputs and gate-line outputs of the N-phase line generator.
// The brake signal exists only when MOTORO3_LG_BRAKE_EN is defined.
interface motoro3_nphase_line_gen_if #(
    parameter int unsigned PHASES = 3,
    parameter int unsigned PWM_W  = 12,
    parameter int unsigned DT_W   = 6,
    parameter int unsigned STEP_W = 4
);
    logic              enable;
    logic [PWM_W-1:0]  pwm_period;
    logic [PWM_W-1:0]  pwm_duty;
    logic [DT_W-1:0]   dead_time;
    logic [STEP_W-1:0] step_in;
`ifdef MOTORO3_LG_BRAKE_EN
    logic              brake;
`endif
    logic [PHASES-1:0] line_hp;
    logic [PHASES-1:0] line_lp;
    logic [STEP_W-1:0] cur_step;
    logic              pwm_wrap;

`ifdef MOTORO3_LG_BRAKE_EN
    modport master (
        output enable, pwm_period, pwm_duty, dead_time, step_in, brake,
        input  line_hp, line_lp, cur_step, pwm_wrap
    );
    modport slave (
        input  enable, pwm_period, pwm_duty, dead_time, step_in, brake,
        output line_hp, line_lp, cur_step, pwm_wrap
    );
`else
    modport master (
        output enable, pwm_period, pwm_duty, dead_time, step_in,
        input  line_hp, line_lp, cur_step, pwm_wrap
    );
    modport slave (
        input  enable, pwm_period, pwm_duty, dead_time, step_in,
        output line_hp, line_lp, cur_step, pwm_wrap
    );
`endif
endinterface

// File: rtl/motoro3_nphase_line_gen.sv
// N-phase PWM line generator: shared timebase, step decode and per-phase dead-time FSMs.
// Optional brake override is built only when MOTORO3_LG_BRAKE_EN is defined.
module motoro3_nphase_line_gen #(
    parameter int unsigned PHASES = 3,
    parameter int unsigned PWM_W  = 12,
    parameter int unsigned DT_W   = 6,
    parameter int unsigned STEP_W = 4
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    motoro3_nphase_line_gen_if.slave bus
);

    typedef enum logic [1:0] {StOff, StHi, StLo, StDead} ch_state_e;

    logic              en_q;
    logic [PWM_W-1:0]  cnt_q, cnt_d;
    logic [PWM_W-1:0]  period_sh_q, period_sh_d;
    logic [PWM_W-1:0]  duty_sh_q, duty_sh_d;
    logic [STEP_W-1:0] step_sh_q, step_sh_d;
    logic [STEP_W-1:0] cur_step_q, cur_step_d;
    logic              wrap_q, wrap_d;

    logic              start, wrap_cond, load, pwm, brake_eff, step_valid;
    logic [PWM_W-1:0]  period_eff, duty_eff;
    logic [STEP_W-1:0] step_eff, hi_idx, lo_idx;
    logic [STEP_W:0]   lo_sum, lo_mod;

    logic [PHASES-1:0] tgt_hi, tgt_lo;
    ch_state_e         state_q [PHASES];
    ch_state_e         state_d [PHASES];
    logic [DT_W-1:0]   dcnt_q  [PHASES];
    logic [DT_W-1:0]   dcnt_d  [PHASES];
    logic [PHASES-1:0] dead_to_hi_q, dead_to_hi_d;
    logic [PHASES-1:0] hp, lp;

    // On the first enabled cycle the shadows are stale, so the live inputs are used directly.
    always_comb begin
        start       = bus.enable & ~en_q;
        period_eff  = start ? bus.pwm_period : period_sh_q;
        duty_eff    = start ? bus.pwm_duty   : duty_sh_q;
        step_eff    = start ? bus.step_in    : step_sh_q;
        wrap_cond   = bus.enable & (cnt_q == period_eff);
        load        = start | wrap_cond;
        cnt_d       = (!bus.enable || wrap_cond) ? '0 : cnt_q + 1'b1;
        wrap_d      = wrap_cond;
        period_sh_d = load ? bus.pwm_period : period_sh_q;
        duty_sh_d   = load ? bus.pwm_duty   : duty_sh_q;
        step_sh_d   = load ? bus.step_in    : step_sh_q;
        cur_step_d  = bus.enable ? step_eff : '1;
        pwm         = cnt_q < duty_eff;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q        <= 1'b0;
            cnt_q       <= '0;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            step_sh_q   <= '1;
            cur_step_q  <= '1;
            wrap_q      <= 1'b0;
        end else begin
            en_q        <= bus.enable;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            step_sh_q   <= step_sh_d;
            cur_step_q  <= cur_step_d;
            wrap_q      <= wrap_d;
        end
    end

`ifdef MOTORO3_LG_BRAKE_EN
    logic brake_hold_q, brake_hold_d;

    // Brake stays latched after release until the next period boundary.
    always_comb begin
        brake_hold_d = bus.enable & (bus.brake | (brake_hold_q & ~load));
        brake_eff    = bus.brake | brake_hold_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            brake_hold_q <= 1'b0;
        end else begin
            brake_hold_q <= brake_hold_d;
        end
    end
`else
    assign brake_eff = 1'b0;
`endif

    // hi = s>>1, lo = (hi + 1 + s[0]) mod PHASES; the sum never exceeds 2*PHASES-1.
    always_comb begin
        hi_idx     = step_eff >> 1;
        lo_sum     = {1'b0, hi_idx} + (STEP_W+1)'(1) + {{STEP_W{1'b0}}, step_eff[0]};
        lo_mod     = (lo_sum >= (STEP_W+1)'(PHASES)) ? lo_sum - (STEP_W+1)'(PHASES) : lo_sum;
        lo_idx     = lo_mod[STEP_W-1:0];
        step_valid = {1'b0, step_eff} < (STEP_W+1)'(2 * PHASES);
        tgt_hi     = '0;
        tgt_lo     = '0;
        for (int unsigned k = 0; k < PHASES; k++) begin
            if (brake_eff) begin
                tgt_lo[k] = 1'b1;
            end else if (step_valid) begin
                if (hi_idx == STEP_W'(k)) begin
                    tgt_hi[k] = pwm;
                    tgt_lo[k] = ~pwm;
                end else if (lo_idx == STEP_W'(k)) begin
                    tgt_lo[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < PHASES; k++) begin
                state_q[k] <= StOff;
                dcnt_q[k]  <= '0;
            end
            dead_to_hi_q <= '0;
        end else begin
            for (int unsigned k = 0; k < PHASES; k++) begin
                state_q[k] <= state_d[k];
                dcnt_q[k]  <= dcnt_d[k];
            end
            dead_to_hi_q <= dead_to_hi_d;
        end
    end

    always_comb begin
        dead_to_hi_d = dead_to_hi_q;
        for (int unsigned k = 0; k < PHASES; k++) begin
            state_d[k] = state_q[k];
            dcnt_d[k]  = dcnt_q[k];
            if (!bus.enable || !(tgt_hi[k] || tgt_lo[k])) begin
                state_d[k] = StOff;
                dcnt_d[k]  = '0;
            end else begin
                unique case (state_q[k])
                    StOff: begin
                        state_d[k] = tgt_hi[k] ? StHi : StLo;
                    end
                    StHi: begin
                        if (tgt_lo[k]) begin
                            if (bus.dead_time == '0) begin
                                state_d[k] = StLo;
                            end else begin
                                state_d[k]      = StDead;
                                dcnt_d[k]       = DT_W'(1);
                                dead_to_hi_d[k] = 1'b0;
                            end
                        end
                    end
                    StLo: begin
                        if (tgt_hi[k]) begin
                            if (bus.dead_time == '0) begin
                                state_d[k] = StHi;
                            end else begin
                                state_d[k]      = StDead;
                                dcnt_d[k]       = DT_W'(1);
                                dead_to_hi_d[k] = 1'b1;
                            end
                        end
                    end
                    StDead: begin
                        if (tgt_hi[k] != dead_to_hi_q[k]) begin
                            // Target swung back to the side just left: no gap needed.
                            state_d[k] = tgt_hi[k] ? StHi : StLo;
                            dcnt_d[k]  = '0;
                        end else if (dcnt_q[k] >= bus.dead_time) begin
                            state_d[k] = dead_to_hi_q[k] ? StHi : StLo;
                            dcnt_d[k]  = '0;
                        end else begin
                            dcnt_d[k] = dcnt_q[k] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[k] = StOff;
                    end
                endcase
            end
        end
    end

    // Gate lines decode straight from the state flops, so Hp and Lp can never overlap.
    always_comb begin
        hp = '0;
        lp = '0;
        for (int unsigned k = 0; k < PHASES; k++) begin
            hp[k] = (state_q[k] == StHi);
            lp[k] = (state_q[k] == StLo);
        end
    end

    assign bus.line_hp  = hp;
    assign bus.line_lp  = lp;
    assign bus.cur_step = cur_step_q;
    assign bus.pwm_wrap = wrap_q;

endmodule
